// File: rtl/store_write_buffer.sv
// Four-entry store write buffer sitting between the MEM-stage store path and
// the unified memory port. Stores are absorbed into a circular FIFO in one
// cycle and drained to memory one at a time whenever the cache fill FSM is
// not using the port. Loads see the youngest buffered store to their address.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | memory not owned; start a write when entries exist and !mem_busy
// ISSUE  | single cycle driving the head entry onto the memory port, pop head
// WAIT   | memory still occupied by the write; count down the remaining cycles
module store_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int WR_LAT = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    input  logic [15:0]                st_addr,
    input  logic [15:0]                st_data,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [15:0]                ld_addr,
    output logic                       ld_hit,
    output logic [15:0]                ld_data,
    input  logic                       mem_busy,
    output logic                       wb_busy,
    output logic                       mem_en,
    output logic                       mem_wr,
    output logic [15:0]                mem_addr,
    output logic [15:0]                mem_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W    = $clog2(DEPTH + 1);
    localparam int LAT_W    = (WR_LAT > 2) ? $clog2(WR_LAT - 1) : 1;
    // WAIT lasts WR_LAT-1 cycles: counter runs from WR_LAT-2 down to 0.
    localparam int LAT_INIT = (WR_LAT >= 2) ? (WR_LAT - 2) : 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e             state_q;
    logic [LAT_W-1:0]   lat_q;

    logic [15:0]        addr_q [DEPTH];
    logic [15:0]        data_q [DEPTH];
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;

    logic               push;
    logic               pop;
    logic               issue;
    logic               fwd_hit;
    logic [15:0]        fwd_data;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    // No pass-through when full: a same-cycle pop does not free the slot early.
    assign st_ready = ~full;
    assign push     = st_valid & ~full;
    assign issue    = (state_q == S_ISSUE);
    assign pop      = issue;

    assign wb_busy  = (state_q != S_IDLE);
    assign mem_en   = issue;
    assign mem_wr   = issue;
    assign mem_addr = issue ? addr_q[head_q] : 16'h0000;
    assign mem_data = issue ? data_q[head_q] : 16'h0000;

    // Occupancy next-state: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO storage and pointers; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= 16'h0000;
                data_q[i] <= 16'h0000;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                addr_q[tail_q] <= st_addr;
                data_q[tail_q] <= st_data;
                tail_q         <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Drain FSM; mem_busy is only looked at in IDLE, so a started write always completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!empty && !mem_busy) begin
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (WR_LAT == 1) begin
                        state_q <= S_IDLE;
                    end else begin
                        lat_q   <= LAT_W'(LAT_INIT);
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lat_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Load forwarding: walk entries oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = 16'h0000;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addr_q[idx] == ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    assign ld_hit  = ld_valid & fwd_hit;
    assign ld_data = ld_hit ? fwd_data : 16'h0000;

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer (DEPTH=4, WR_LAT=4).
module tb_store_write_buffer;

    localparam int DEPTH  = 4;
    localparam int WR_LAT = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic             st_valid;
    logic [15:0]      st_addr;
    logic [15:0]      st_data;
    logic             st_ready;
    logic             ld_valid;
    logic [15:0]      ld_addr;
    logic             ld_hit;
    logic [15:0]      ld_data;
    logic             mem_busy;
    logic             wb_busy;
    logic             mem_en;
    logic             mem_wr;
    logic [15:0]      mem_addr;
    logic [15:0]      mem_data;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;

    int errors = 0;
    int checks = 0;

    store_write_buffer #(.DEPTH(DEPTH), .WR_LAT(WR_LAT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .st_valid (st_valid),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_ready (st_ready),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_hit   (ld_hit),
        .ld_data  (ld_data),
        .mem_busy (mem_busy),
        .wb_busy  (wb_busy),
        .mem_en   (mem_en),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        st_valid = 1'b0;
        st_addr  = 16'h0;
        st_data  = 16'h0;
        ld_valid = 1'b0;
        ld_addr  = 16'h0;
        mem_busy = 1'b0;
        #3;
        // ---- reset state ----
        chk("rst_st_ready", 32'(st_ready), 1);
        chk("rst_empty",    32'(empty),    1);
        chk("rst_full",     32'(full),     0);
        chk("rst_count",    32'(count),    0);
        chk("rst_wb_busy",  32'(wb_busy),  0);
        chk("rst_mem_en",   32'(mem_en),   0);
        chk("rst_mem_wr",   32'(mem_wr),   0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_data", 32'(mem_data), 0);
        chk("rst_ld_hit",   32'(ld_hit),   0);
        chk("rst_ld_data",  32'(ld_data),  0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // ---- single store 0x0010/0xBEEF ----
        st_valid = 1'b1; st_addr = 16'h0010; st_data = 16'hBEEF;
        #1;
        chk("t1_ready", 32'(st_ready), 1);
        tick();                               // accepted at this edge
        st_valid = 1'b0;
        ld_valid = 1'b1; ld_addr = 16'h0010;
        #1;
        chk("t1_count1",  32'(count),   1);
        chk("t1_en_acc",  32'(mem_en),  0);
        chk("t1_busy_acc",32'(wb_busy), 0);
        chk("t1_fwd_hit", 32'(ld_hit),  1);
        chk("t1_fwd_dat", 32'(ld_data), 32'hBEEF);
        tick();                               // ISSUE
        chk("t1_issue_en",   32'(mem_en),   1);
        chk("t1_issue_wr",   32'(mem_wr),   1);
        chk("t1_issue_addr", 32'(mem_addr), 32'h0010);
        chk("t1_issue_data", 32'(mem_data), 32'hBEEF);
        chk("t1_issue_busy", 32'(wb_busy),  1);
        chk("t1_issue_hit",  32'(ld_hit),   1);
        ld_valid = 1'b0;
        for (int w = 0; w < WR_LAT - 1; w++) begin
            tick();                           // WAIT cycles
            chk("t1_wait_en",   32'(mem_en),  0);
            chk("t1_wait_busy", 32'(wb_busy), 1);
            chk("t1_wait_cnt",  32'(count),   0);
        end
        tick();                               // back in IDLE
        chk("t1_idle_busy", 32'(wb_busy), 0);
        chk("t1_idle_en",   32'(mem_en),  0);
        chk("t1_empty",     32'(empty),   1);

        // ---- fill while memory busy, then drain in order ----
        mem_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            st_valid = 1'b1;
            st_addr  = 16'h0100 + 16'(i);
            st_data  = 16'hA000 + 16'(i);
            #1;
            chk("t2_ready", 32'(st_ready), (i < 4) ? 1 : 0);
            tick();
        end
        st_valid = 1'b0;
        #1;
        chk("t2_full",  32'(full),     1);
        chk("t2_count", 32'(count),    4);
        chk("t2_ready_full", 32'(st_ready), 0);
        chk("t2_hold_busy",  32'(wb_busy),  0);
        tick();
        chk("t2_hold_en", 32'(mem_en), 0);
        mem_busy = 1'b0;
        tick();
        for (int j = 0; j < 4; j++) begin
            chk("t2_drain_en",   32'(mem_en),   1);
            chk("t2_drain_addr", 32'(mem_addr), 32'h0100 + j);
            chk("t2_drain_data", 32'(mem_data), 32'hA000 + j);
            for (int w = 0; w < WR_LAT; w++) begin
                tick();
                chk("t2_gap_en", 32'(mem_en), 0);
                if (j == 0 && w == 0) begin
                    chk("t2_ready_after_pop", 32'(st_ready), 1);
                    chk("t2_count_after_pop", 32'(count),    3);
                end
            end
            tick();
        end
        chk("t2_no_fifth_en", 32'(mem_en), 0);
        chk("t2_drained_cnt", 32'(count),  0);
        chk("t2_drained_emp", 32'(empty),  1);

        // ---- forwarding: youngest duplicate wins ----
        mem_busy = 1'b1;
        st_valid = 1'b1; st_addr = 16'h0020; st_data = 16'h1111;
        tick();
        st_data = 16'h2222;
        tick();
        st_valid = 1'b0;
        ld_valid = 1'b1; ld_addr = 16'h0020;
        #1;
        chk("t3_hit",  32'(ld_hit),  1);
        chk("t3_data", 32'(ld_data), 32'h2222);
        ld_addr = 16'h0022;
        #1;
        chk("t3_miss_hit",  32'(ld_hit),  0);
        chk("t3_miss_data", 32'(ld_data), 0);
        ld_valid = 1'b0; ld_addr = 16'h0020;
        #1;
        chk("t3_noreq_hit", 32'(ld_hit), 0);

        // ---- full buffer, store offered during the ISSUE pop ----
        st_valid = 1'b1; st_addr = 16'h0030; st_data = 16'h3333;
        tick();
        st_addr = 16'h0031; st_data = 16'h4444;
        tick();
        st_valid = 1'b0;
        #1;
        chk("t4_full",  32'(full),  1);
        chk("t4_count", 32'(count), 4);
        mem_busy = 1'b0;
        tick();                               // ISSUE of 0x0020/0x1111
        st_valid = 1'b1; st_addr = 16'h0040; st_data = 16'h5555;
        #1;
        chk("t4_issue_en",   32'(mem_en),   1);
        chk("t4_issue_addr", 32'(mem_addr), 32'h0020);
        chk("t4_issue_data", 32'(mem_data), 32'h1111);
        chk("t4_no_accept",  32'(st_ready), 0);
        tick();                               // WAIT, store still offered
        mem_busy = 1'b1;
        #1;
        chk("t4_count3", 32'(count),    3);
        chk("t4_ready",  32'(st_ready), 1);
        chk("t5_busy_w0", 32'(wb_busy), 1);
        tick();                               // accepted, tail wrapped
        st_valid = 1'b0;
        #1;
        chk("t4_count4",  32'(count),   4);
        chk("t4_full2",   32'(full),    1);
        chk("t5_busy_w1", 32'(wb_busy), 1);
        chk("t5_en_w1",   32'(mem_en),  0);
        tick();
        chk("t5_busy_w2", 32'(wb_busy), 1);
        tick();                               // IDLE, held by mem_busy
        chk("t5_idle_busy", 32'(wb_busy), 0);
        for (int w = 0; w < 3; w++) begin
            tick();
            chk("t5_hold_en",   32'(mem_en),  0);
            chk("t5_hold_busy", 32'(wb_busy), 0);
        end
        ld_valid = 1'b1; ld_addr = 16'h0040;
        #1;
        chk("t4_wrap_hit",  32'(ld_hit),  1);
        chk("t4_wrap_data", 32'(ld_data), 32'h5555);
        ld_addr = 16'h0020;
        #1;
        chk("t4_dup_left", 32'(ld_data), 32'h2222);
        ld_valid = 1'b0;
        mem_busy = 1'b0;
        tick();                               // ISSUE of 0x0020/0x2222
        chk("t5_resume_en",   32'(mem_en),   1);
        chk("t5_resume_data", 32'(mem_data), 32'h2222);
        for (int w = 0; w < WR_LAT + 1; w++) tick();
        // ---- reset during ISSUE with 3 entries ----
        chk("t6_issue_en",   32'(mem_en),   1);
        chk("t6_issue_cnt",  32'(count),    3);
        chk("t6_issue_addr", 32'(mem_addr), 32'h0030);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_en",   32'(mem_en),  0);
        chk("t6_rst_busy", 32'(wb_busy), 0);
        tick();
        rst_n = 1'b1;
        for (int w = 0; w < 6; w++) begin
            tick();
            chk("t6_post_en", 32'(mem_en), 0);
        end
        ld_valid = 1'b1; ld_addr = 16'h0040;
        #1;
        chk("t6_post_cnt", 32'(count),  0);
        chk("t6_post_emp", 32'(empty),  1);
        chk("t6_post_hit", 32'(ld_hit), 0);
        ld_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_write_buffer.md
# store_write_buffer

Four-entry write buffer between the MEM-stage store path and the unified `memory4c` port. D-cache store hits/misses are written through to memory. The buffer absorbs each store in one cycle instead of stalling MEM, and drains entries to memory whenever the cache fill FSM is not using it. Loads get same-cycle forwarding from the youngest buffered store to the same address.

## Interface
- `DEPTH`, 4, number of entries (power of two, ≥2)
- `WR_LAT`, 4, cycles memory is occupied per write, counting the issue cycle (≥1)
- `clk` in 1: system clock, rising edge
- `rst_n` in 1: reset; one clock; reset is asynchronous and active-low
- `st_valid` in 1: store request from MEM stage
- `st_addr` in 16: store word address
- `st_data` in 16: store data
- `st_ready` out 1: entry available; store accepted on `st_valid & st_ready`
- `ld_valid` in 1: load lookup request
- `ld_addr` in 16: load address
- `ld_hit` out 1: buffered store matches `ld_addr`
- `ld_data` out 16: data of youngest matching entry; 0 when no hit
- `mem_busy` in 1: cache fill FSM owns memory (its `fsm_busy`)
- `wb_busy` out 1: buffer owns memory; fill FSM must not start a miss while high
- `mem_en` out 1: memory enable
- `mem_wr` out 1: memory write strobe
- `mem_addr` out 16: memory address
- `mem_data` out 16: memory write data
- `count` out clog2(DEPTH+1): valid entries
- `empty` out 1, `full` out 1

## Operation
- Circular FIFO: head pointer, tail pointer and count, all registered. Pointers wrap modulo DEPTH.
- Push on `st_valid & st_ready`: write the tail entry, tail+1, count+1. `st_ready = ~full`. No pass-through when full, even if a pop occurs the same cycle.
- Duplicate addresses are not coalesced; each store is its own entry and drains in order.
- Drain FSM states:
  - IDLE: `wb_busy=0`. Go to ISSUE when `~empty & ~mem_busy`; otherwise stay.
  - ISSUE: one cycle. Drive `mem_en=mem_wr=1` with `mem_addr`/`mem_data` from the head entry. Pop the head at the end of the cycle (head+1, count−1). If WR_LAT=1 go to IDLE; else load the latency counter with WR_LAT−2 and go to WAIT.
  - WAIT: `mem_*=0`. When the counter is 0 go to IDLE; else decrement.
- `wb_busy=1` in ISSUE and WAIT.
- `mem_busy` is sampled only in IDLE. Once ISSUE is entered, the write completes regardless of `mem_busy`.
- Push and pop in the same cycle: count unchanged, both pointers advance. A push into an empty buffer can be issued no earlier than the following cycle.
- Forwarding is combinational. `ld_hit = ld_valid` & any valid entry with `addr == ld_addr`, compared on all 16 bits.
  - Youngest entry (closest to tail) wins.
  - The head entry in ISSUE still participates.
  - A store pushed in the same cycle is not visible until the next cycle.
- `mem_*` outputs are combinational from state and head entry. They are 0 outside ISSUE.

## Timing
- Reset (async assert): all entries invalid, head=tail=count=0, state IDLE, counter 0. Outputs: `st_ready=1`, `empty=1`, `full=0`, `count=0`, `wb_busy=0`, `mem_en=mem_wr=0`, `mem_addr=mem_data=0`, `ld_hit=0`, `ld_data=0`.
- Reset mid-write: `mem_en` drops immediately and the buffered stores are discarded.
- Store accepted at edge k into an empty buffer, with `mem_busy=0`:
  - ISSUE during cycle k+1..k+2, so `mem_en` is high one cycle after acceptance.
  - Pop at edge k+2.
  - IDLE at edge k+1+WR_LAT.
  - Next issue starts at edge k+2+WR_LAT.
- Sustained drain rate: one store per WR_LAT+1 cycles.
- `mem_busy` high in IDLE holds the buffer indefinitely. It fills to DEPTH, then `st_ready=0` backpressures MEM.

## Test plan
- Single store 0x0010/0xBEEF, idle memory: `mem_en/mem_wr` high exactly one cycle, 1 cycle after acceptance, `mem_addr=0x0010`, `mem_data=0xBEEF`; `wb_busy` high WR_LAT cycles; `count` 1→0.
- `mem_busy=1`, push 5 stores back-to-back: first 4 accepted, `full=1`, `st_ready=0` on 5th. Release `mem_busy`: writes drain in push order, WR_LAT+1 cycles apart; `st_ready` returns after first pop.
- Stores 0x0020/0x1111 then 0x0020/0x2222 buffered, load 0x0020: `ld_hit=1`, `ld_data=0x2222`. Load 0x0022: `ld_hit=0`, `ld_data=0`.
- Full buffer with store and ISSUE pop in same cycle: store not accepted; `count` 4→3; next cycle store accepted, `count` back to 4; tail wraps to 0 correctly.
- `mem_busy` rising during WAIT: current write completes, `wb_busy` stays high to the end of WAIT; the next entry is not issued until `mem_busy` falls.
- Assert `rst_n=0` during ISSUE with 3 entries: `mem_en` drops same cycle; after release `count=0`, `empty=1`, no further memory writes.
